// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 does invert/add/OR, stage 2 does the shift and derives flags.
// Valid/ready handshake on both sides; data registers carry no reset.
module alu_pipe #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned SHIFT_AMT  = $clog2(DATA_WIDTH),
   parameter bit          FLAGS_EN   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] data_in_a,
   input  logic [DATA_WIDTH-1:0] data_in_b,
   input  logic                  invert_a,
   input  logic                  invert_b,
   input  logic                  invert_out,
   input  logic                  or_enable,
   input  logic                  carry_in,
   input  logic [1:0]            shift_mode,
   input  logic [SHIFT_AMT-1:0]  shift_code,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  carry_out,
   output logic                  flag_zero,
   output logic                  flag_neg,
   output logic                  flag_ovf
);

   localparam int unsigned Msb = DATA_WIDTH - 1;

   typedef enum logic [1:0] {
      ShNone = 2'b00,
      ShSll  = 2'b01,
      ShSrl  = 2'b10,
      ShSra  = 2'b11
   } shift_e;

   // Handshake
   logic s1_valid_q, s1_valid_d;
   logic s2_valid_q, s2_valid_d;
   logic s1_advance;
   logic s1_accept;

   // Stage 1 payload
   logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
   logic                  s1_carry_q, s1_carry_d;
   logic                  s1_ovf_q, s1_ovf_d;
   logic [1:0]            s1_mode_q;
   logic [SHIFT_AMT-1:0]  s1_code_q;

   // Stage 2 payload
   logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
   logic                  s2_carry_q;
   logic                  s2_ovf_q;
   logic                  s2_zero_q, s2_zero_d;
   logic                  s2_neg_q, s2_neg_d;

   // Stage 1 datapath
   logic [DATA_WIDTH-1:0] a_op, b_op, raw_res;
   logic [DATA_WIDTH:0]   sum;

   // S1 may move forward whenever S2 is empty or draining this cycle
   assign s1_advance = !s2_valid_q || out_ready;
   assign in_ready   = !rst && (!s1_valid_q || s1_advance);
   assign s1_accept  = in_valid && in_ready;

   always_comb begin
      a_op    = invert_a ? ~data_in_a : data_in_a;
      b_op    = invert_b ? ~data_in_b : data_in_b;
      sum     = {1'b0, a_op} + {1'b0, b_op} + {{DATA_WIDTH{1'b0}}, carry_in};
      raw_res = or_enable ? (a_op | b_op) : sum[DATA_WIDTH-1:0];

      s1_data_d  = invert_out ? ~raw_res : raw_res;
      s1_carry_d = !or_enable && sum[DATA_WIDTH];
      // Overflow looks at the un-inverted result
      s1_ovf_d   = !or_enable && (a_op[Msb] == b_op[Msb]) && (raw_res[Msb] != a_op[Msb]);
   end

   // Stage 2 datapath: shift then derive flags from the final value
   always_comb begin
      s2_data_d = s1_data_q;
      unique case (shift_e'(s1_mode_q))
         ShSll:   s2_data_d = s1_data_q << s1_code_q;
         ShSrl:   s2_data_d = s1_data_q >> s1_code_q;
         ShSra:   s2_data_d = DATA_WIDTH'($signed(s1_data_q) >>> s1_code_q);
         default: s2_data_d = s1_data_q;
      endcase
      s2_zero_d = (s2_data_d == '0);
      s2_neg_d  = s2_data_d[Msb];
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      if (s1_advance) begin
         s2_valid_d = s1_valid_q;
      end
      if (in_ready) begin
         s1_valid_d = in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (s1_accept) begin
         s1_data_q  <= s1_data_d;
         s1_carry_q <= s1_carry_d;
         s1_ovf_q   <= s1_ovf_d;
         s1_mode_q  <= shift_mode;
         s1_code_q  <= shift_code;
      end
   end

   always_ff @(posedge clk) begin
      if (s1_advance && s1_valid_q) begin
         s2_data_q  <= s2_data_d;
         s2_carry_q <= s1_carry_q;
         s2_ovf_q   <= s1_ovf_q;
         s2_zero_q  <= s2_zero_d;
         s2_neg_q   <= s2_neg_d;
      end
   end

   // Outputs read as zero whenever no result is being offered
   assign out_valid = s2_valid_q;
   assign data_out  = s2_valid_q ? s2_data_q : '0;
   assign carry_out = s2_valid_q && s2_carry_q;
   assign flag_zero = FLAGS_EN && s2_valid_q && s2_zero_q;
   assign flag_neg  = FLAGS_EN && s2_valid_q && s2_neg_q;
   assign flag_ovf  = FLAGS_EN && s2_valid_q && s2_ovf_q;

endmodule
